// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, FSM states and result normalisation.
package fpu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 3;

  localparam logic [OP_W-1:0] FOP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] FOP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] FOP_MUL  = 4'd2;
  localparam logic [OP_W-1:0] FOP_DIV  = 4'd3;
  localparam logic [OP_W-1:0] FOP_NEG  = 4'd4;
  localparam logic [OP_W-1:0] FOP_ABS  = 4'd5;
  localparam logic [OP_W-1:0] FOP_SQRT = 4'd6;
  localparam logic [OP_W-1:0] FOP_SLT  = 4'd7;

  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} fpu_state_e;

  // Negative zero collapses to +0; unassigned opcodes yield zero.
  function automatic logic [31:0] fpu_normalise(logic [OP_W-1:0] op, logic [31:0] res);
    if (op > FOP_SLT) return 32'h0;
    if (res == NEG_ZERO) return 32'h0;
    return res;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue, FPU-datapath and writeback signals of the FPU issue controller.
interface fpu_issue_ctrl_if
  import fpu_pkg::*;
#(
  parameter int unsigned RD_W = 6
);
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [RD_W-1:0] req_rd;
  logic            kill;
  logic [OP_W-1:0] fpu_ctl;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic [31:0]     fpu_res;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, kill, fpu_res, wb_ready,
    input  req_ready, fpu_ctl, fpu_a, fpu_b, wb_valid, wb_data, wb_rd, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, kill, fpu_res, wb_ready,
    output req_ready, fpu_ctl, fpu_a, fpu_b, wb_valid, wb_data, wb_rd, busy
  );
endinterface

// File: rtl/fpu_lat_lut.sv
// Opcode to execution-latency lookup for the FPU issue controller.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 1,
  parameter int unsigned LAT_DIV  = 4,
  parameter int unsigned LAT_SQRT = 4
) (
  input  logic [OP_W-1:0]  op_i,
  output logic [CNT_W-1:0] lat_o
);

  if (LAT_ADD > 7 || LAT_MUL > 7 || LAT_DIV > 7 || LAT_SQRT > 7) begin : g_lat_range
    $error("fpu_lat_lut: latency parameters must fit the 3-bit counter (<= 7)");
  end

  always_comb begin
    lat_o = '0;
    case (op_i)
      FOP_ADD, FOP_SUB: lat_o = CNT_W'(LAT_ADD);
      FOP_MUL:          lat_o = CNT_W'(LAT_MUL);
      FOP_DIV:          lat_o = CNT_W'(LAT_DIV);
      FOP_SQRT:         lat_o = CNT_W'(LAT_SQRT);
      default:          lat_o = '0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue sequencer for the shared FPU: latches an op, waits out its latency,
// buffers the result for writeback and stalls the core while busy.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 1,
  parameter int unsigned LAT_DIV  = 4,
  parameter int unsigned LAT_SQRT = 4,
  parameter int unsigned RD_W     = 6
) (
  input logic            clk,
  input logic            rst,
  fpu_issue_ctrl_if.slave bus
);

  fpu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] ctl_q, ctl_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] lat;
  logic            req_ready;
  logic            accept;

  fpu_lat_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT)
  ) u_lat_lut (
    .op_i  (bus.req_op),
    .lat_o (lat)
  );

  always_comb begin
    req_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.wb_ready);
    accept     = bus.req_valid & req_ready & ~bus.kill;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctl_d      = ctl_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;

    if (accept) begin
      ctl_d = bus.req_op;
      a_d   = bus.req_a;
      b_d   = bus.req_b;
      rd_d  = bus.req_rd;
      cnt_d = lat;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        if (bus.kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          wb_valid_d = 1'b1;
          wb_data_d  = fpu_normalise(ctl_q, bus.fpu_res);
          wb_rd_d    = rd_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // kill outranks both the writeback handshake and a back-to-back accept.
        if (bus.kill) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = accept ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctl_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_q      <= ctl_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.fpu_ctl   = ctl_q;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
